// File: rtl/core_halt_monitor_if.sv
// Retire-side signal bundle between the core and its halt monitor.
// The monitor takes the slave view; the core or bench drives through master.
interface core_halt_monitor_if;
  logic        clear;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retire_instr;
  logic        ebreak_pulse;
  logic        timeout_pulse;
  logic        halted;
  logic        halt_req;
  logic [31:0] halt_pc;
  logic [63:0] cycle_count;
  logic [63:0] instret_count;

  modport master (
    output clear, retire_valid, retire_pc, retire_instr,
    input  ebreak_pulse, timeout_pulse, halted, halt_req,
           halt_pc, cycle_count, instret_count
  );

  modport slave (
    input  clear, retire_valid, retire_pc, retire_instr,
    output ebreak_pulse, timeout_pulse, halted, halt_req,
           halt_pc, cycle_count, instret_count
  );
endinterface

// File: rtl/core_halt_monitor.sv
// Retire-side monitor: counts RUN cycles and retired instructions, halts on
// EBREAK, and stops the run when the cycle budget is exhausted.
module core_halt_monitor #(
  parameter logic [63:0] TIMEOUT_CYCLES = 64'd5_000_000_000,
  parameter logic [31:0] EBREAK_ENC     = 32'h0010_0073
) (
  input  logic                clk,
  input  logic                rst,
  core_halt_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    TOUT = 2'd2
  } state_t;

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 64'd0);

  state_t      state;
  logic        ebreak_pulse;
  logic        timeout_pulse;
  logic [31:0] halt_pc;
  logic [63:0] cycle_count;
  logic [63:0] instret_count;

  logic is_ebreak;
  logic timeout_hit;

  always_comb begin
    is_ebreak   = mon.retire_valid && (mon.retire_instr == EBREAK_ENC);
    timeout_hit = TIMEOUT_EN && ((cycle_count + 64'd1) == TIMEOUT_CYCLES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      ebreak_pulse  <= 1'b0;
      timeout_pulse <= 1'b0;
      halt_pc       <= '0;
      cycle_count   <= '0;
      instret_count <= '0;
    end else if (mon.clear) begin
      state         <= RUN;
      ebreak_pulse  <= 1'b0;
      timeout_pulse <= 1'b0;
      halt_pc       <= '0;
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      ebreak_pulse  <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        RUN: begin
          cycle_count <= cycle_count + 64'd1;
          if (mon.retire_valid) instret_count <= instret_count + 64'd1;
          // EBREAK outranks a timeout landing on the same edge
          if (is_ebreak) begin
            halt_pc      <= mon.retire_pc;
            ebreak_pulse <= 1'b1;
            state        <= HALT;
          end else if (timeout_hit) begin
            timeout_pulse <= 1'b1;
            state         <= TOUT;
          end
        end
        HALT, TOUT: ;
        default: state <= RUN;
      endcase
    end
  end

  assign mon.ebreak_pulse  = ebreak_pulse;
  assign mon.timeout_pulse = timeout_pulse;
  assign mon.halted        = (state != RUN);
  assign mon.halt_req      = (state != RUN);
  assign mon.halt_pc       = halt_pc;
  assign mon.cycle_count   = cycle_count;
  assign mon.instret_count = instret_count;

endmodule

// File: tb/tb_core_halt_monitor.sv
// Bench for core_halt_monitor: directed scenarios on three budget settings
// plus randomized retire streams checked against a behavioural model.
module tb_core_halt_monitor;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst20 = 1'b1, rst10 = 1'b1;
  always #5 clk = ~clk;

  core_halt_monitor_if bus0();
  core_halt_monitor_if bus20();
  core_halt_monitor_if bus10();

  core_halt_monitor dut0 (.clk(clk), .rst(rst0), .mon(bus0));
  core_halt_monitor #(.TIMEOUT_CYCLES(64'd20)) dut20 (.clk(clk), .rst(rst20), .mon(bus20));
  core_halt_monitor #(.TIMEOUT_CYCLES(64'd10)) dut10 (.clk(clk), .rst(rst10), .mon(bus10));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          running;
    bit          eb;
    bit          to;
    logic [31:0] hpc;
    logic [63:0] cyc;
    logic [63:0] ins;
  } model_t;

  // One clock edge of the monitor's documented behaviour.
  function automatic model_t model_step(model_t m, bit rv, logic [31:0] instr,
                                        logic [31:0] pc, bit clr, logic [63:0] budget);
    model_t n = m;
    n.eb = 0;
    n.to = 0;
    if (clr) begin
      n.running = 1; n.hpc = 0; n.cyc = 0; n.ins = 0;
    end else if (m.running) begin
      n.cyc = m.cyc + 1;
      if (rv) n.ins = m.ins + 1;
      if (rv && instr == EBREAK) begin
        n.hpc = pc; n.eb = 1; n.running = 0;
      end else if (budget != 0 && n.cyc == budget) begin
        n.to = 1; n.running = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [163:0] model_vec(model_t m);
    return {m.eb, m.to, !m.running, !m.running, m.hpc, m.cyc, m.ins};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus0.clear = 0;  bus0.retire_valid = 0;  bus0.retire_pc = '0;  bus0.retire_instr = NOP;
    bus20.clear = 0; bus20.retire_valid = 0; bus20.retire_pc = '0; bus20.retire_instr = NOP;
    bus10.clear = 0; bus10.retire_valid = 0; bus10.retire_pc = '0; bus10.retire_instr = NOP;
  endtask

  task automatic test_reset();
    logic [163:0] got;
    for (int i = 0; i < 4; i++) tick();
    got = {bus0.ebreak_pulse, bus0.timeout_pulse, bus0.halted, bus0.halt_req,
           bus0.halt_pc, bus0.cycle_count, bus0.instret_count};
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", got);
    end
    rst0 = 0;
  endtask

  task automatic test_basic();
    for (int c = 1; c <= 11; c++) begin
      bus0.retire_valid = (c % 3 == 2);
      bus0.retire_instr = (c == 11) ? EBREAK : NOP;
      bus0.retire_pc    = (c == 11) ? 32'h10 : 32'(c * 4);
      tick();
      bus0.retire_valid = 0;
      if (c == 10) begin
        n_tests++;
        if ({bus0.ebreak_pulse, bus0.halted, bus0.cycle_count, bus0.instret_count} !==
            {1'b0, 1'b0, 64'd10, 64'd3}) begin
          n_fail++;
          $display("FAIL basic_pre eb=%b halted=%b cyc=%0d ins=%0d exp 0 0 10 3",
                   bus0.ebreak_pulse, bus0.halted, bus0.cycle_count, bus0.instret_count);
        end
      end
    end
    n_tests++;
    if ({bus0.ebreak_pulse, bus0.timeout_pulse, bus0.halted, bus0.halt_req, bus0.halt_pc,
         bus0.cycle_count, bus0.instret_count} !== {4'b1011, 32'h10, 64'd11, 64'd4}) begin
      n_fail++;
      $display("FAIL basic_ebreak eb=%b to=%b h=%b hr=%b pc=%h cyc=%0d ins=%0d exp 1 0 1 1 10 11 4",
               bus0.ebreak_pulse, bus0.timeout_pulse, bus0.halted, bus0.halt_req,
               bus0.halt_pc, bus0.cycle_count, bus0.instret_count);
    end
    tick();
    n_tests++;
    if ({bus0.ebreak_pulse, bus0.halted, bus0.cycle_count} !== {2'b01, 64'd11}) begin
      n_fail++;
      $display("FAIL basic_pulse_width eb=%b halted=%b cyc=%0d exp 0 1 11",
               bus0.ebreak_pulse, bus0.halted, bus0.cycle_count);
    end
  endtask

  task automatic test_halt_ignore();
    for (int i = 0; i < 5; i++) begin
      bus0.retire_valid = 1;
      bus0.retire_instr = EBREAK;
      bus0.retire_pc    = $urandom;
      tick();
      bus0.retire_valid = 0;
      n_tests++;
      if ({bus0.ebreak_pulse, bus0.halted, bus0.halt_pc, bus0.cycle_count, bus0.instret_count} !==
          {2'b01, 32'h10, 64'd11, 64'd4}) begin
        n_fail++;
        $display("FAIL halt_ignore[%0d] eb=%b h=%b pc=%h cyc=%0d ins=%0d exp 0 1 10 11 4", i,
                 bus0.ebreak_pulse, bus0.halted, bus0.halt_pc, bus0.cycle_count, bus0.instret_count);
      end
    end
  endtask

  task automatic test_clear();
    bus0.clear = 1; bus0.retire_valid = 1; bus0.retire_instr = EBREAK; bus0.retire_pc = 32'h40;
    tick();
    bus0.clear = 0; bus0.retire_valid = 0;
    n_tests++;
    if ({bus0.ebreak_pulse, bus0.halted, bus0.halt_pc, bus0.cycle_count, bus0.instret_count} !== '0) begin
      n_fail++;
      $display("FAIL clear_from_halt eb=%b h=%b pc=%h cyc=%0d ins=%0d exp all 0",
               bus0.ebreak_pulse, bus0.halted, bus0.halt_pc, bus0.cycle_count, bus0.instret_count);
    end
    tick(); tick();
    bus0.clear = 1; bus0.retire_valid = 1; bus0.retire_instr = EBREAK; bus0.retire_pc = 32'h44;
    tick();
    bus0.clear = 0; bus0.retire_valid = 0;
    n_tests++;
    if ({bus0.ebreak_pulse, bus0.halted, bus0.halt_pc, bus0.cycle_count} !== '0) begin
      n_fail++;
      $display("FAIL clear_vs_ebreak eb=%b h=%b pc=%h cyc=%0d exp all 0",
               bus0.ebreak_pulse, bus0.halted, bus0.halt_pc, bus0.cycle_count);
    end
    for (int c = 1; c <= 5; c++) begin
      bus0.retire_valid = (c == 2 || c == 4);
      bus0.retire_instr = NOP;
      tick();
      bus0.retire_valid = 0;
    end
    n_tests++;
    if ({bus0.halted, bus0.cycle_count, bus0.instret_count} !== {1'b0, 64'd5, 64'd2}) begin
      n_fail++;
      $display("FAIL clear_resume h=%b cyc=%0d ins=%0d exp 0 5 2",
               bus0.halted, bus0.cycle_count, bus0.instret_count);
    end
  endtask

  task automatic test_async_reset();
    logic [163:0] got;
    bus0.retire_valid = 1; bus0.retire_instr = EBREAK; bus0.retire_pc = 32'h80;
    tick();
    bus0.retire_valid = 0;
    #3 rst0 = 1;
    #1;
    got = {bus0.ebreak_pulse, bus0.timeout_pulse, bus0.halted, bus0.halt_req,
           bus0.halt_pc, bus0.cycle_count, bus0.instret_count};
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=0", got);
    end
    #1 rst0 = 0;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if ({bus0.halted, bus0.ebreak_pulse, bus0.cycle_count} !== {2'b00, 64'd3}) begin
      n_fail++;
      $display("FAIL async_reset_resume h=%b eb=%b cyc=%0d exp 0 0 3",
               bus0.halted, bus0.ebreak_pulse, bus0.cycle_count);
    end
  endtask

  task automatic test_timeout();
    logic [63:0] ecyc;
    logic        eto, eh;
    rst20 = 0;
    for (int c = 1; c <= 22; c++) begin
      bus20.retire_valid = (c % 4 == 0);
      bus20.retire_instr = NOP;
      tick();
      bus20.retire_valid = 0;
      ecyc = (c < 20) ? 64'(c) : 64'd20;
      eto  = (c == 20);
      eh   = (c >= 20);
      n_tests++;
      if ({bus20.timeout_pulse, bus20.ebreak_pulse, bus20.halted, bus20.cycle_count,
           bus20.instret_count} !== {eto, 1'b0, eh, ecyc, ecyc / 4}) begin
        n_fail++;
        $display("FAIL timeout[%0d] to=%b eb=%b h=%b cyc=%0d ins=%0d exp %b 0 %b %0d %0d", c,
                 bus20.timeout_pulse, bus20.ebreak_pulse, bus20.halted, bus20.cycle_count,
                 bus20.instret_count, eto, eh, ecyc, ecyc / 4);
      end
    end
  endtask

  task automatic test_ebreak_vs_timeout();
    rst10 = 0;
    for (int c = 1; c <= 10; c++) begin
      bus10.retire_valid = (c == 10);
      bus10.retire_instr = EBREAK;
      bus10.retire_pc    = 32'h24;
      tick();
      bus10.retire_valid = 0;
    end
    n_tests++;
    if ({bus10.ebreak_pulse, bus10.timeout_pulse, bus10.halted, bus10.halt_pc,
         bus10.cycle_count, bus10.instret_count} !== {3'b101, 32'h24, 64'd10, 64'd1}) begin
      n_fail++;
      $display("FAIL ebreak_vs_timeout eb=%b to=%b h=%b pc=%h cyc=%0d ins=%0d exp 1 0 1 24 10 1",
               bus10.ebreak_pulse, bus10.timeout_pulse, bus10.halted, bus10.halt_pc,
               bus10.cycle_count, bus10.instret_count);
    end
    tick();
    n_tests++;
    if ({bus10.ebreak_pulse, bus10.timeout_pulse, bus10.halted} !== 3'b001) begin
      n_fail++;
      $display("FAIL ebreak_vs_timeout_after eb=%b to=%b h=%b exp 0 0 1",
               bus10.ebreak_pulse, bus10.timeout_pulse, bus10.halted);
    end
  endtask

  task automatic test_random();
    model_t       m0, m20;
    logic [163:0] got, exp;
    bit           rv0, rv20, cl0, cl20;
    logic [31:0]  in0, in20, pc0, pc20;
    rst0 = 1; rst20 = 1;
    idle_all();
    tick();
    rst0 = 0; rst20 = 0;
    m0  = '{running: 1, eb: 0, to: 0, hpc: '0, cyc: '0, ins: '0};
    m20 = m0;
    for (int i = 0; i < 3000; i++) begin
      rv0  = ($urandom_range(0, 2) == 0);
      rv20 = ($urandom_range(0, 2) == 0);
      cl0  = ($urandom_range(0, 39) == 0);
      cl20 = ($urandom_range(0, 29) == 0);
      in0  = ($urandom_range(0, 24) == 0) ? EBREAK :
             (($urandom_range(0, 9) == 0) ? (EBREAK ^ (32'd1 << $urandom_range(0, 31))) : $urandom);
      in20 = ($urandom_range(0, 24) == 0) ? EBREAK : $urandom;
      pc0  = $urandom;
      pc20 = $urandom;
      bus0.retire_valid  = rv0;  bus0.retire_instr  = in0;  bus0.retire_pc  = pc0;  bus0.clear  = cl0;
      bus20.retire_valid = rv20; bus20.retire_instr = in20; bus20.retire_pc = pc20; bus20.clear = cl20;
      tick();
      m0  = model_step(m0,  rv0,  in0,  pc0,  cl0,  64'd5_000_000_000);
      m20 = model_step(m20, rv20, in20, pc20, cl20, 64'd20);
      got = {bus0.ebreak_pulse, bus0.timeout_pulse, bus0.halted, bus0.halt_req,
             bus0.halt_pc, bus0.cycle_count, bus0.instret_count};
      exp = model_vec(m0);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rand_default[%0d] got=%h exp=%h", i, got, exp);
      end
      got = {bus20.ebreak_pulse, bus20.timeout_pulse, bus20.halted, bus20.halt_req,
             bus20.halt_pc, bus20.cycle_count, bus20.instret_count};
      exp = model_vec(m20);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rand_budget20[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_basic();
    test_halt_ignore();
    test_clear();
    test_async_reset();
    test_timeout();
    test_ebreak_vs_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
